// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down sweep controller and its counter core.
package updown_sweep_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_REPS_W = 4;

  // Explicit encodings keep the state register layout stable for anyone
  // probing it in a waveform or a legacy debug bus.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/updown_counter_core.sv
// Loadable up/down counter. Load wins over step; clears to 0 on reset.
module updown_counter_core
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] STEP = 1;

  // Counter register: load, else step one in the requested direction.
  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values, independent of block ordering in the simulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= down ? (count - STEP) : (count + STEP);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: runs a counter core between latched lo/hi
// bounds for a programmed number of cycles (0 = until abort).
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int REPS_W = DEF_REPS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [REPS_W-1:0] reps,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [REPS_W-1:0] ONE_REP = 1;

  sweep_state_e      state, state_nxt;
  logic [WIDTH-1:0]  lo_q, hi_q;
  logic [REPS_W-1:0] reps_q, rep_cnt, rep_nxt;
  logic              mode_q;

  logic              ctr_en, ctr_load, ctr_down;
  logic [WIDTH-1:0]  ctr_load_val;
  logic              latch_cfg, cfg_bad, rep_inc, last_rep;

  assign rep_nxt  = rep_cnt + ONE_REP;
  // Only a finite sweep can finish; reps == 0 never matches here.
  assign last_rep = (reps_q != '0) && (rep_nxt == reps_q);

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (ctr_en),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .down     (ctr_down),
    .count    (count)
  );

  // Next-state and counter-core control decode.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    ctr_en       = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_val = lo;
    ctr_down     = 1'b0;
    latch_cfg    = 1'b0;
    cfg_bad      = 1'b0;
    rep_inc      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (lo >= hi) begin
            cfg_bad = 1'b1;
          end else begin
            latch_cfg    = 1'b1;
            ctr_load     = 1'b1;
            ctr_load_val = mode ? hi : lo;
            state_nxt    = mode ? ST_DOWN : ST_UP;
          end
        end
      end

      ST_UP: begin
        // Abort outranks both the turn-around and the cycle end.
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (count != hi_q) begin
          ctr_en = 1'b1;
        end else if (!mode_q) begin
          ctr_en    = 1'b1;
          ctr_down  = 1'b1;
          state_nxt = ST_DOWN;
        end else begin
          rep_inc = (reps_q != '0);
          if (last_rep) begin
            state_nxt = ST_DONE;
          end else begin
            ctr_en    = 1'b1;
            ctr_down  = 1'b1;
            state_nxt = ST_DOWN;
          end
        end
      end

      ST_DOWN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (count != lo_q) begin
          ctr_en   = 1'b1;
          ctr_down = 1'b1;
        end else if (mode_q) begin
          ctr_en    = 1'b1;
          state_nxt = ST_UP;
        end else begin
          rep_inc = (reps_q != '0);
          if (last_rep) begin
            state_nxt = ST_DONE;
          end else begin
            ctr_en    = 1'b1;
            state_nxt = ST_UP;
          end
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus status flags registered from the next state, so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      dir     <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == ST_UP) || (state_nxt == ST_DOWN);
      dir     <= (state_nxt == ST_DOWN);
      done    <= (state_nxt == ST_DONE);
      cfg_err <= cfg_bad;
    end
  end

  // Sweep configuration, captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q   <= '0;
      hi_q   <= '0;
      reps_q <= '0;
      mode_q <= 1'b0;
    end else if (latch_cfg) begin
      lo_q   <= lo;
      hi_q   <= hi;
      reps_q <= reps;
      mode_q <= mode;
    end
  end

  // Completed-cycle counter; frozen in infinite mode so it cannot overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (latch_cfg) begin
      rep_cnt <= '0;
    end else if (rep_inc) begin
      rep_cnt <= rep_nxt;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: stimulus pushes expected output
// snapshots, a monitor pops one whenever busy/done/cfg_err is shown.
module tb_updown_sweep_ctrl;

  typedef struct packed {
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       cfg_err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, mode;
  logic [3:0] lo, hi, reps;
  logic [3:0] count;
  logic       dir, busy, done, cfg_err;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;

  updown_sweep_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .lo      (lo),
    .hi      (hi),
    .reps    (reps),
    .count   (count),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t cur_obs();
    return {count, dir, busy, done, cfg_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input bit d, input bit b, input bit dn,
                      input bit ce);
    obs_t o;
    o.count   = 4'(c);
    o.dir     = d;
    o.busy    = b;
    o.done    = dn;
    o.cfg_err = ce;
    exp_q.push_back(o);
  endtask

  // Present a start with the given config for one cycle; returns on the
  // falling edge where the first response is visible.
  task automatic kick(input int l, input int h, input bit m, input int r);
    @(negedge clk);
    lo    = 4'(l);
    hi    = 4'(h);
    mode  = m;
    reps  = 4'(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for the monitor to consume everything, then a few idle
  // cycles so stray outputs get flagged as spurious.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every presented output must match the head of the queue.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (rst && (busy || done || cfg_err)) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", cur_obs(), 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("obs#%0d", n_pop), cur_obs(), e);
          n_pop++;
        end
      end
    end
  end

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    lo = '0; hi = '0; reps = '0;
    #1;
    check("reset_outputs", cur_obs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", cur_obs(), 0);

    // Single up-first cycle 2..5..2.
    push(2, 0, 1, 0, 0); push(3, 0, 1, 0, 0); push(4, 0, 1, 0, 0);
    push(5, 0, 1, 0, 0); push(4, 1, 1, 0, 0); push(3, 1, 1, 0, 0);
    push(2, 1, 1, 0, 0); push(2, 0, 0, 1, 0);
    kick(2, 5, 1'b0, 1);
    drain("up_first_drain");
    check("up_first_hold", cur_obs(), {4'd2, 4'b0000});

    // Two down-first cycles over the full range: 31 + 30 values.
    for (int v = 15; v >= 0; v--) push(v, 1, 1, 0, 0);
    for (int v = 1; v <= 15; v++) push(v, 0, 1, 0, 0);
    for (int v = 14; v >= 0; v--) push(v, 1, 1, 0, 0);
    for (int v = 1; v <= 15; v++) push(v, 0, 1, 0, 0);
    push(15, 0, 0, 1, 0);
    kick(0, 15, 1'b1, 2);
    drain("full_range_drain");
    check("full_range_hold", cur_obs(), {4'd15, 4'b0000});

    // Rejected start: lo == hi.
    push(15, 0, 0, 0, 1);
    kick(7, 7, 1'b0, 1);
    drain("cfg_err_drain");
    check("cfg_err_hold", cur_obs(), {4'd15, 4'b0000});

    // Infinite sweep 1..3, aborted while showing 3 in UP.
    for (int k = 0; k < 23; k++) begin
      case (k % 4)
        0:       push((k == 0) ? 1 : 3, 0, 1, 0, 0);
        1:       push(2, 1, 1, 0, 0);
        2:       push(1, 1, 1, 0, 0);
        default: push(2, 0, 1, 0, 0);
      endcase
    end
    // Entry 0 is the loaded 1; fix up the first two steps of the pattern.
    exp_q[exp_q.size()-23] = {4'd1, 4'b0100};
    exp_q[exp_q.size()-22] = {4'd2, 4'b0100};
    exp_q[exp_q.size()-21] = {4'd3, 4'b0100};
    exp_q[exp_q.size()-20] = {4'd2, 4'b1100};
    exp_q[exp_q.size()-19] = {4'd1, 4'b1100};
    for (int k = 5; k < 23; k++) begin
      case ((k - 5) % 4)
        0:       exp_q[exp_q.size()-23+k] = {4'd2, 4'b0100};
        1:       exp_q[exp_q.size()-23+k] = {4'd3, 4'b0100};
        2:       exp_q[exp_q.size()-23+k] = {4'd2, 4'b1100};
        default: exp_q[exp_q.size()-23+k] = {4'd1, 4'b1100};
      endcase
    end
    kick(1, 3, 1'b0, 0);
    repeat (22) @(negedge clk);
    check("pre_abort", cur_obs(), {4'd3, 4'b0100});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_hold", cur_obs(), {4'd3, 4'b0000});
    drain("abort_drain");

    // Start with new bounds while busy must be ignored.
    push(2, 0, 1, 0, 0); push(3, 0, 1, 0, 0); push(4, 0, 1, 0, 0);
    push(3, 1, 1, 0, 0); push(2, 1, 1, 0, 0); push(2, 0, 0, 1, 0);
    kick(2, 4, 1'b0, 1);
    @(negedge clk);
    lo = 4'd0; hi = 4'd9; mode = 1'b1; reps = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("busy_start_drain");
    check("busy_start_hold", cur_obs(), {4'd2, 4'b0000});

    // Asynchronous reset in the middle of a sweep.
    push(0, 0, 1, 0, 0); push(1, 0, 1, 0, 0);
    push(2, 0, 1, 0, 0); push(3, 0, 1, 0, 0);
    kick(0, 15, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", cur_obs(), 0);
    @(negedge clk);
    rst = 1'b1;
    drain("reset_drain");
    check("reset_idle", cur_obs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
